// File: rtl/ctrl_decode_stage.sv
// Decode stage: a small instruction queue feeding a registered RV32I/M control decoder.
// Illegal encodings still flow to the output with insn_vld_ctrl cleared, and a saturating counter tracks them.
`timescale 1ns/1ps
module ctrl_decode_stage #(
  parameter int QDEPTH = 4,
  parameter int M_EXT  = 1,
  parameter int CNT_W  = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [31:0]      i_inst,
  input  logic [31:0]      i_pc,
  input  logic             i_inst_vld,
  output logic             o_inst_rdy,
  input  logic             i_stall,
  input  logic             i_flush,
  output logic             o_vld,
  output logic [31:0]      o_pc,
  output logic [31:0]      o_inst,
  output logic             o_insn_vld_ctrl,
  output logic [2:0]       o_imm_sel,
  output logic             o_rd_wren,
  output logic             o_br_un,
  output logic             o_bsel,
  output logic             o_asel,
  output logic [3:0]       o_alu_op,
  output logic             o_wren,
  output logic [2:0]       o_slt_sl,
  output logic [1:0]       o_wb_sel,
  output logic             o_ctrl,
  output logic             o_md_en,
  output logic [2:0]       o_md_op,
  output logic [CNT_W-1:0] o_illegal_cnt
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [PW:0] CNT_FULL = (PW+1)'(QDEPTH);

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_IMM    = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111
  } opcode_e;

  typedef struct packed {
    logic       vld;
    logic [2:0] imm_sel;
    logic       rd_wren;
    logic       br_un;
    logic       bsel;
    logic       asel;
    logic [3:0] alu_op;
    logic       wren;
    logic [2:0] slt_sl;
    logic [1:0] wb_sel;
    logic       ctrl;
    logic       md_en;
    logic [2:0] md_op;
  } ctrl_t;

  logic [31:0] q_inst [QDEPTH];
  logic [31:0] q_pc   [QDEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          push, pop;
  logic [31:0]   head_inst, head_pc;
  logic [2:0]    f3;
  logic [6:0]    f7;
  logic          legal;
  ctrl_t         dec, out_ctrl;

  assign o_inst_rdy = i_rst_n & (count != CNT_FULL) & ~i_flush;
  assign push       = i_inst_vld & o_inst_rdy;
  assign pop        = (count != '0) & (~o_vld | ~i_stall);

  assign head_inst = q_inst[rd_ptr];
  assign head_pc   = q_pc[rd_ptr];
  assign f3        = head_inst[14:12];
  assign f7        = head_inst[31:25];

  always_ff @(posedge i_clk) begin
    if (push) begin
      q_inst[wr_ptr] <= i_inst;
      q_pc[wr_ptr]   <= i_pc;
    end
  end

  always_comb begin
    dec   = '0;
    legal = 1'b1;
    case (head_inst[6:0])
      OP_R: begin
        if (f7 == 7'b0000000 || f7 == 7'b0100000) begin
          dec.rd_wren = 1'b1;
          dec.wb_sel  = 2'b01;
          dec.alu_op  = {head_inst[30] & (f3 == 3'b000 || f3 == 3'b101), f3};
        end else if (f7 == 7'b0000001 && M_EXT != 0) begin
          dec.md_en   = 1'b1;
          dec.md_op   = f3;
          dec.rd_wren = 1'b1;
          dec.wb_sel  = 2'b01;
        end else begin
          legal = 1'b0;
        end
      end
      OP_IMM: begin
        dec.rd_wren = 1'b1;
        dec.wb_sel  = 2'b01;
        dec.bsel    = 1'b1;
        dec.alu_op  = {head_inst[30] & (f3 == 3'b101), f3};
      end
      OP_LOAD: begin
        dec.rd_wren = 1'b1;
        dec.bsel    = 1'b1;
        case (f3)
          3'b000:  dec.slt_sl = 3'b011;
          3'b001:  dec.slt_sl = 3'b100;
          3'b010:  dec.slt_sl = 3'b101;
          3'b100:  dec.slt_sl = 3'b110;
          3'b101:  dec.slt_sl = 3'b111;
          default: legal = 1'b0;
        endcase
      end
      OP_STORE: begin
        dec.imm_sel = 3'b001;
        dec.bsel    = 1'b1;
        dec.wren    = 1'b1;
        dec.wb_sel  = 2'b11;
        dec.slt_sl  = f3;
        if (f3[2] || f3 == 3'b011) legal = 1'b0;
      end
      OP_BRANCH: begin
        dec.imm_sel = 3'b010;
        dec.asel    = 1'b1;
        dec.bsel    = 1'b1;
        dec.wb_sel  = 2'b11;
        dec.ctrl    = 1'b1;
        dec.br_un   = ~(f3 == 3'b100 || f3 == 3'b101);
        if (f3 == 3'b010 || f3 == 3'b011) legal = 1'b0;
      end
      OP_JAL: begin
        dec.imm_sel = 3'b011;
        dec.rd_wren = 1'b1;
        dec.asel    = 1'b1;
        dec.bsel    = 1'b1;
        dec.wb_sel  = 2'b10;
        dec.ctrl    = 1'b1;
      end
      OP_JALR: begin
        dec.rd_wren = 1'b1;
        dec.bsel    = 1'b1;
        dec.wb_sel  = 2'b10;
        dec.ctrl    = 1'b1;
      end
      OP_LUI: begin
        dec.imm_sel = 3'b100;
        dec.rd_wren = 1'b1;
        dec.bsel    = 1'b1;
        dec.alu_op  = 4'b1111;
        dec.wb_sel  = 2'b01;
      end
      OP_AUIPC: begin
        dec.imm_sel = 3'b101;
        dec.rd_wren = 1'b1;
        dec.asel    = 1'b1;
        dec.bsel    = 1'b1;
        dec.wb_sel  = 2'b01;
      end
      default: legal = 1'b0;
    endcase
    // Illegal entries present an all-zero control word.
    if (!legal) dec = '0;
    else        dec.vld = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      o_vld         <= 1'b0;
      o_pc          <= '0;
      o_inst        <= '0;
      out_ctrl      <= '0;
      o_illegal_cnt <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      o_vld  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + PW'(1);
        o_vld    <= 1'b1;
        o_pc     <= head_pc;
        o_inst   <= head_inst;
        out_ctrl <= dec;
        if (!dec.vld && o_illegal_cnt != '1) o_illegal_cnt <= o_illegal_cnt + CNT_W'(1);
      end else if (o_vld && !i_stall) begin
        o_vld <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign o_insn_vld_ctrl = out_ctrl.vld;
  assign o_imm_sel       = out_ctrl.imm_sel;
  assign o_rd_wren       = out_ctrl.rd_wren;
  assign o_br_un         = out_ctrl.br_un;
  assign o_bsel          = out_ctrl.bsel;
  assign o_asel          = out_ctrl.asel;
  assign o_alu_op        = out_ctrl.alu_op;
  assign o_wren          = out_ctrl.wren;
  assign o_slt_sl        = out_ctrl.slt_sl;
  assign o_wb_sel        = out_ctrl.wb_sel;
  assign o_ctrl          = out_ctrl.ctrl;
  assign o_md_en         = out_ctrl.md_en;
  assign o_md_op         = out_ctrl.md_op;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Scoreboard bench for ctrl_decode_stage: a default instance and an M_EXT=0 / CNT_W=2 instance share one stimulus stream.
`timescale 1ns/1ps
module tb_ctrl_decode_stage;

  localparam int QD = 4;

  typedef struct packed {
    logic       vld;
    logic [2:0] imm_sel;
    logic       rd_wren;
    logic       br_un;
    logic       bsel;
    logic       asel;
    logic [3:0] alu_op;
    logic       wren;
    logic [2:0] slt_sl;
    logic [1:0] wb_sel;
    logic       ctrl;
    logic       md_en;
    logic [2:0] md_op;
  } dec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    dec_t        da;
    dec_t        db;
    int unsigned ca;
    int unsigned cb;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] inst, pc;
  logic inst_vld, stall, flush;

  logic a_rdy, a_vld, a_ivc, a_rdw, a_brun, a_bsel, a_asel, a_wren, a_ctrl, a_mden;
  logic [31:0] a_pc, a_inst;
  logic [2:0] a_imm, a_slt, a_mdop;
  logic [3:0] a_alu;
  logic [1:0] a_wb;
  logic [7:0] a_cnt;

  logic b_rdy, b_vld, b_ivc, b_rdw, b_brun, b_bsel, b_asel, b_wren, b_ctrl, b_mden;
  logic [31:0] b_pc, b_inst;
  logic [2:0] b_imm, b_slt, b_mdop;
  logic [3:0] b_alu;
  logic [1:0] b_wb;
  logic [1:0] b_cnt;

  always #5 clk = ~clk;

  ctrl_decode_stage #(.QDEPTH(QD), .M_EXT(1), .CNT_W(8)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_inst(inst), .i_pc(pc), .i_inst_vld(inst_vld),
    .o_inst_rdy(a_rdy), .i_stall(stall), .i_flush(flush), .o_vld(a_vld), .o_pc(a_pc),
    .o_inst(a_inst), .o_insn_vld_ctrl(a_ivc), .o_imm_sel(a_imm), .o_rd_wren(a_rdw),
    .o_br_un(a_brun), .o_bsel(a_bsel), .o_asel(a_asel), .o_alu_op(a_alu), .o_wren(a_wren),
    .o_slt_sl(a_slt), .o_wb_sel(a_wb), .o_ctrl(a_ctrl), .o_md_en(a_mden), .o_md_op(a_mdop),
    .o_illegal_cnt(a_cnt)
  );

  ctrl_decode_stage #(.QDEPTH(QD), .M_EXT(0), .CNT_W(2)) u_dut_alt (
    .i_clk(clk), .i_rst_n(rst_n), .i_inst(inst), .i_pc(pc), .i_inst_vld(inst_vld),
    .o_inst_rdy(b_rdy), .i_stall(stall), .i_flush(flush), .o_vld(b_vld), .o_pc(b_pc),
    .o_inst(b_inst), .o_insn_vld_ctrl(b_ivc), .o_imm_sel(b_imm), .o_rd_wren(b_rdw),
    .o_br_un(b_brun), .o_bsel(b_bsel), .o_asel(b_asel), .o_alu_op(b_alu), .o_wren(b_wren),
    .o_slt_sl(b_slt), .o_wb_sel(b_wb), .o_ctrl(b_ctrl), .o_md_en(b_mden), .o_md_op(b_mdop),
    .o_illegal_cnt(b_cnt)
  );

  dec_t a_dec, b_dec;
  assign a_dec = {a_ivc, a_imm, a_rdw, a_brun, a_bsel, a_asel, a_alu, a_wren, a_slt, a_wb, a_ctrl, a_mden, a_mdop};
  assign b_dec = {b_ivc, b_imm, b_rdw, b_brun, b_bsel, b_asel, b_alu, b_wren, b_slt, b_wb, b_ctrl, b_mden, b_mdop};

  int unsigned passes = 0;
  int unsigned total  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference decoder built from the opcode/funct rules.
  function automatic dec_t ref_dec(input logic [31:0] w, input bit m);
    dec_t d;
    logic [6:0] op, f7;
    logic [2:0] f3;
    bit ok, found;
    logic [2:0] ld_f3 [5];
    d = '0; ok = 1'b1; found = 1'b0;
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    if (op == 7'h33) begin
      if (f7 == 7'h00 || f7 == 7'h20) begin
        d.rd_wren = 1; d.wb_sel = 2'b01;
        d.alu_op = {(w[30] == 1'b1) && (f3 == 3'd0 || f3 == 3'd5), f3};
      end else if (f7 == 7'h01 && m) begin
        d.md_en = 1; d.md_op = f3; d.rd_wren = 1; d.wb_sel = 2'b01;
      end else ok = 0;
    end else if (op == 7'h13) begin
      d.rd_wren = 1; d.wb_sel = 2'b01; d.bsel = 1;
      d.alu_op = {(w[30] == 1'b1) && (f3 == 3'd5), f3};
    end else if (op == 7'h03) begin
      d.rd_wren = 1; d.bsel = 1;
      for (int i = 0; i < 5; i++)
        if (ld_f3[i] == f3) begin d.slt_sl = 3'(3 + i); found = 1; end
      ok = found;
    end else if (op == 7'h23) begin
      d.imm_sel = 3'd1; d.bsel = 1; d.wren = 1; d.wb_sel = 2'b11; d.slt_sl = f3;
      ok = (f3 <= 3'd2);
    end else if (op == 7'h63) begin
      d.imm_sel = 3'd2; d.asel = 1; d.bsel = 1; d.wb_sel = 2'b11; d.ctrl = 1;
      d.br_un = !(f3 == 3'd4 || f3 == 3'd5);
      ok = !(f3 == 3'd2 || f3 == 3'd3);
    end else if (op == 7'h6F) begin
      d.imm_sel = 3'd3; d.rd_wren = 1; d.asel = 1; d.bsel = 1; d.wb_sel = 2'b10; d.ctrl = 1;
    end else if (op == 7'h67) begin
      d.rd_wren = 1; d.bsel = 1; d.wb_sel = 2'b10; d.ctrl = 1;
    end else if (op == 7'h37) begin
      d.imm_sel = 3'd4; d.rd_wren = 1; d.bsel = 1; d.alu_op = 4'hF; d.wb_sel = 2'b01;
    end else if (op == 7'h17) begin
      d.imm_sel = 3'd5; d.rd_wren = 1; d.asel = 1; d.bsel = 1; d.wb_sel = 2'b01;
    end else ok = 0;
    if (!ok) d = '0;
    else d.vld = 1'b1;
    return d;
  endfunction

  // Behavioural model state: pending queue, output-occupied flag, illegal counters.
  ent_t        mq[$];
  exp_t        exp_q[$];
  bit          m_full = 0;
  int unsigned m_ca = 0, m_cb = 0;
  bit          exp_vld_now = 0, exp_rdy = 0;
  bit          mon_en = 0;

  task automatic step(input bit v, input logic [31:0] w, input logic [31:0] p, input bit st, input bit fl);
    bit do_pop, do_push;
    ent_t e;
    exp_t x;
    inst_vld = v; inst = w; pc = p; stall = st; flush = fl;
    exp_vld_now = m_full;
    exp_rdy     = (mq.size() < QD) && !fl;
    if (fl) begin
      mq.delete();
      m_full = 0;
    end else begin
      do_pop  = (mq.size() > 0) && (!m_full || !st);
      do_push = v && exp_rdy;
      if (do_pop) begin
        e = mq.pop_front();
        x.pc = e.pc; x.inst = e.inst;
        x.da = ref_dec(e.inst, 1'b1);
        x.db = ref_dec(e.inst, 1'b0);
        if (!x.da.vld && m_ca < 255) m_ca++;
        if (!x.db.vld && m_cb < 3) m_cb++;
        x.ca = m_ca; x.cb = m_cb;
        exp_q.push_back(x);
        m_full = 1;
      end else if (m_full && !st) begin
        m_full = 0;
      end
      if (do_push) begin
        e.pc = p; e.inst = w;
        mq.push_back(e);
      end
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] w, input logic [31:0] p, input bit st, input bit fl);
    @(posedge clk);
    #2;
    step(v, w, p, st, fl);
  endtask

  // Monitor: compares the presented entry every cycle; pops it when consumed or flushed.
  exp_t mon_e;
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      chk("o_vld", a_vld, exp_vld_now);
      chk("o_inst_rdy", a_rdy, exp_rdy);
      chk("alt_o_vld", b_vld, exp_vld_now);
      chk("alt_o_inst_rdy", b_rdy, exp_rdy);
      if (a_vld) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_output: got pc %h inst %h, expected no output", a_pc, a_inst);
        end else begin
          mon_e = exp_q[0];
          chk("o_pc", a_pc, mon_e.pc);
          chk("o_inst", a_inst, mon_e.inst);
          chk("ctrl", a_dec, mon_e.da);
          chk("illegal_cnt", a_cnt, mon_e.ca);
          chk("alt_pc", b_pc, mon_e.pc);
          chk("alt_ctrl", b_dec, mon_e.db);
          chk("alt_illegal_cnt", b_cnt, mon_e.cb);
          if (!stall || flush) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_vld"}, {a_vld, b_vld}, 0);
    chk({tag, "_rdy"}, {a_rdy, b_rdy}, 0);
    chk({tag, "_pc"}, {a_pc, b_pc}, 0);
    chk({tag, "_inst"}, {a_inst, b_inst}, 0);
    chk({tag, "_ctrl"}, {a_dec, b_dec}, 0);
    chk({tag, "_cnt"}, {a_cnt, b_cnt}, 0);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [6:0] ops [10];
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h33};
    w = $urandom;
    if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 9)];
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h01;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    rst_n = 1'b0; inst_vld = 0; inst = '0; pc = '0; stall = 0; flush = 0;
    repeat (2) @(posedge clk);
    #2;
    chk_zero("reset");
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0);
    mon_en = 1;

    // add, then sub/lw back to back
    drive(1, 32'h002081B3, 32'h100, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 0);
    drive(1, 32'h40208133, 32'h104, 0, 0);
    drive(1, 32'h0000A183, 32'h108, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 0);

    // fill under continuous stall, then release
    for (int i = 0; i < 8; i++) drive(1, 32'h00000093 | (32'(i) << 20), 32'h200 + 32'(4 * i), 1, 0);
    repeat (8) drive(0, 0, 0, 0, 0);

    // mul: legal with M, illegal without
    drive(1, 32'h027302B3, 32'h300, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 0);

    // three entries under stall, flush with a concurrent push
    for (int i = 0; i < 3; i++) drive(1, 32'h0000A183, 32'h400 + 32'(4 * i), 1, 0);
    drive(1, 32'h00500093, 32'hBAD0, 1, 1);
    repeat (4) drive(0, 0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 500; i++)
      drive($urandom_range(0, 3) != 0, rand_inst(), $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0);

    // illegal-count saturation on both widths
    for (int i = 0; i < 270; i++) drive(1, 32'hFFFFFFFF, 32'h800 + 32'(4 * i), 0, 0);
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) drive(0, 0, 0, 0, 0);
    chk("drain_empty", exp_q.size(), 0);
    chk("sat_cnt", a_cnt, 255);
    chk("alt_sat_cnt", b_cnt, 3);

    // asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) drive(1, 32'h002081B3, 32'h900 + 32'(4 * i), 1, 0);
    @(posedge clk);
    #3;
    mon_en = 0;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
